// File: rtl/sha256_iter_if.sv
// Block-level handshake bundle for the iterative SHA-256 engine: the
// block/start request from the padding source and the chained digest going
// out to the hex-dump path. Bit 0 of block_in and digest is the MSB.
interface sha256_iter_if;
   logic         start;
   logic         first;
   logic         abort;
   logic [0:511] block_in;
   logic         ready;
   logic         digest_valid;
   logic [0:255] digest;

   // Requester side: issues blocks, observes the engine state and digest.
   modport master (
      output start,
      output first,
      output abort,
      output block_in,
      input  ready,
      input  digest_valid,
      input  digest
   );

   // Engine side.
   modport slave (
      input  start,
      input  first,
      input  abort,
      input  block_in,
      output ready,
      output digest_valid,
      output digest
   );
endinterface

// File: rtl/sha256_iter.sv
// Iterative, chainable SHA-256 compression engine. One pre-padded 512-bit
// block per accepted start; ROUNDS_PER_CYCLE rounds are chained per clock,
// the message schedule is produced on the fly from a 16-word sliding window,
// and the intermediate hash is kept so multi-block messages can be chained.
module sha256_iter #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic          CLK,
   input  logic          reset,
   sha256_iter_if.slave  bus
);

   // Only power-of-two round counts that divide 64 keep the round counter exact.
   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
       ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rounds
      $error("sha256_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam logic [5:0] T_STEP = 6'(ROUNDS_PER_CYCLE);
   localparam logic [5:0] T_LAST = 6'(64 - ROUNDS_PER_CYCLE);

   // Initial hash value; index 0 is H0 (packed concatenation lists H7 first).
   localparam logic [7:0][31:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   // Round constants K[0..63].
   localparam logic [31:0] K_TAB [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_FINAL
   } state_t;

   // ------------------------------------------------------------------
   // SHA-256 bit functions (32-bit, modulo 2^32 by construction)
   // ------------------------------------------------------------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_q;
   logic [5:0]        t_q;          // index of the first round done next cycle
   logic [15:0][31:0] w_q;          // W[t] .. W[t+15]; index 0 is oldest
   logic [7:0][31:0]  wv_q;         // working vars, 0=a .. 7=h
   logic [7:0][31:0]  hash_q;       // chaining value, 0=H0 .. 7=H7
   logic              ready_q;
   logic              digest_valid_q;

   logic [15:0][31:0] w_d;
   logic [7:0][31:0]  wv_d;
   logic [0:255]      digest_d;

   // One clock's worth of rounds: extend the schedule by R words, then run
   // R chained rounds; the window slides by R words.
   always_comb begin : round_comb
      logic [31:0]      ext [0:23];
      logic [7:0][31:0] v;
      logic [31:0]      t1;
      logic [31:0]      t2;
      t1 = '0;
      t2 = '0;
      for (int i = 0; i < 16; i++) begin
         ext[i] = w_q[i];
      end
      for (int i = 16; i < 24; i++) begin
         ext[i] = '0;
      end
      // W[t+16+j] may depend on words produced earlier in the same cycle.
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
      end
      v = wv_q;
      for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
         t1 = v[7] + bsig1(v[4]) + ch(v[4], v[5], v[6]) + K_TAB[t_q + 6'(j)] + ext[j];
         t2 = bsig0(v[0]) + maj(v[0], v[1], v[2]);
         v[7] = v[6];
         v[6] = v[5];
         v[5] = v[4];
         v[4] = v[3] + t1;
         v[3] = v[2];
         v[2] = v[1];
         v[1] = v[0];
         v[0] = t1 + t2;
      end
      wv_d = v;
      for (int i = 0; i < 16; i++) begin
         w_d[i] = ext[i + ROUNDS_PER_CYCLE];
      end
   end

   // Control FSM with registered ready/digest_valid; abort beats completion.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         t_q            <= '0;
         w_q            <= '0;
         wv_q           <= '0;
         hash_q         <= IV;
         ready_q        <= 1'b1;
         digest_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // start wins over a simultaneous abort here
               if (bus.start) begin
                  for (int i = 0; i < 16; i++) begin
                     w_q[i] <= bus.block_in[32*i +: 32];
                  end
                  wv_q           <= bus.first ? IV : hash_q;
                  if (bus.first) begin
                     hash_q <= IV;
                  end
                  t_q            <= '0;
                  digest_valid_q <= 1'b0;
                  ready_q        <= 1'b0;
                  state_q        <= S_ROUND;
               end
            end
            S_ROUND: begin
               if (bus.abort) begin
                  t_q     <= '0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  wv_q <= wv_d;
                  w_q  <= w_d;
                  t_q  <= t_q + T_STEP;
                  if (t_q == T_LAST) begin
                     state_q <= S_FINAL;
                  end
               end
            end
            S_FINAL: begin
               if (!bus.abort) begin
                  for (int i = 0; i < 8; i++) begin
                     hash_q[i] <= hash_q[i] + wv_q[i];
                  end
                  digest_valid_q <= 1'b1;
               end
               t_q     <= '0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               t_q     <= '0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Present H0..H7 MSB-first on the digest bus.
   always_comb begin
      digest_d = '0;
      for (int i = 0; i < 8; i++) begin
         digest_d[32*i +: 32] = hash_q[i];
      end
   end

   assign bus.ready        = ready_q;
   assign bus.digest_valid = digest_valid_q;
   assign bus.digest       = digest_d;

endmodule

// File: tb/tb_sha256_iter.sv
// Scoreboard bench for sha256_iter: drivers push expected digests (from a
// plain FIPS 180-4 compression model or known answers) into queues, and
// monitors pop and compare whenever digest_valid rises.
`timescale 1ns/1ps
module tb_sha256_iter;

   localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] ABC_KAT   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_KAT = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_KAT   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_B1    = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};

   localparam logic [31:0] KT [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef struct {
      logic [255:0] dig;
      int           t0;
   } exp_t;

   logic clk;
   logic reset_n;
   logic rx_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   extras_done;

   // ---------------- reference model ----------------
   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] v [0:7];
      logic [31:0] t1;
      logic [31:0] t2;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
      return r;
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
      return b;
   endfunction

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired, condition not reached", name);
   endtask

   // ---------------- clock / cycle counter ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- main DUT, R=1 ----------------
   sha256_iter_if m_if();
   sha256_iter #(.ROUNDS_PER_CYCLE(1)) dut (
      .CLK   (clk),
      .reset (reset_n),
      .bus   (m_if)
   );

   exp_t         exp_q[$];
   logic         m_pdv;
   logic [255:0] model_hash;
   int           m_blk;

   // Monitor: every rising digest_valid must match the oldest expectation.
   always @(negedge clk) begin : m_mon
      exp_t e;
      if (!reset_n) begin
         m_pdv = 1'b0;
      end else begin
         if (m_if.digest_valid && !m_pdv) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_digest: got digest_valid rise %h, required none", m_if.digest);
            end else begin
               e = exp_q.pop_front();
               chk("R1_digest", m_if.digest, e.dig);
               chk("R1_latency", 256'(cyc - e.t0), 256'(65));
               $display("R1 block %0d digest=%h latency=%0d", m_blk, m_if.digest, cyc - e.t0);
               m_blk++;
            end
         end
         m_pdv = m_if.digest_valid;
      end
   end

   task automatic submit(input logic [511:0] blk, input logic f, input logic push, input logic ab);
      int n;
      logic [255:0] e;
      n = 0;
      @(negedge clk);
      while (m_if.ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (m_if.ready !== 1'b1) begin
         note_fail("R1_ready_timeout");
         return;
      end
      m_if.start    = 1'b1;
      m_if.first    = f;
      m_if.abort    = ab;
      m_if.block_in = blk;
      @(posedge clk);
      #1;
      m_if.start    = 1'b0;
      m_if.abort    = 1'b0;
      m_if.block_in = rand_block();
      if (push) begin
         e = ref_compress(f ? IV : model_hash, blk);
         model_hash = e;
         exp_q.push_back('{dig: e, t0: cyc});
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_if.ready !== 1'b1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || m_if.ready !== 1'b1) note_fail("R1_drain_timeout");
   endtask

   // ---------------- R = 2, 4, 8 instances ----------------
   for (genvar gi = 1; gi < 4; gi++) begin : g_r
      localparam int R   = 1 << gi;
      localparam int LAT = 64 / R + 1;
      sha256_iter_if bus();
      sha256_iter #(.ROUNDS_PER_CYCLE(R)) dut_r (
         .CLK   (clk),
         .reset (rx_n),
         .bus   (bus)
      );
      exp_t         q[$];
      logic         pdv;
      logic [255:0] mh;
      int           nblk;

      always @(negedge clk) begin : mon
         exp_t e;
         if (!rx_n) begin
            pdv = 1'b0;
         end else begin
            if (bus.digest_valid && !pdv) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL R%0d_spurious_digest: got digest_valid rise, required none", R);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("R%0d_digest", R), bus.digest, e.dig);
                  chk($sformatf("R%0d_latency", R), 256'(cyc - e.t0), 256'(LAT));
                  $display("R%0d block %0d digest=%h latency=%0d", R, nblk, bus.digest, cyc - e.t0);
                  nblk++;
               end
            end
            pdv = bus.digest_valid;
         end
      end

      initial begin : drv
         logic [511:0] blk;
         logic         f;
         logic [255:0] e;
         int           n;
         bus.start = 1'b0;
         bus.first = 1'b0;
         bus.abort = 1'b0;
         bus.block_in = '0;
         mh = IV;
         nblk = 0;
         wait (rx_n === 1'b1);
         for (int k = 0; k < 6; k++) begin
            if (k == 0) blk = EMPTY_BLK;
            else if (k == 1) blk = ABC_BLK;
            else blk = rand_block();
            f = (k < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            n = 0;
            @(negedge clk);
            while (bus.ready !== 1'b1 && n < 200) begin
               @(negedge clk);
               n++;
            end
            if (bus.ready !== 1'b1) begin
               note_fail($sformatf("R%0d_ready_timeout", R));
               break;
            end
            bus.start = 1'b1;
            bus.first = f;
            bus.block_in = blk;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.block_in = rand_block();
            if (k == 0) e = EMPTY_KAT;
            else if (k == 1) e = ABC_KAT;
            else e = ref_compress(f ? IV : mh, blk);
            mh = e;
            q.push_back('{dig: e, t0: cyc});
         end
         n = 0;
         while ((q.size() != 0 || bus.ready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (q.size() != 0) note_fail($sformatf("R%0d_drain_timeout", R));
         extras_done++;
      end
   end

   // ---------------- main stimulus ----------------
   initial begin : main
      int busy;
      int n;
      logic [255:0] inter;
      n_checks = 0;
      n_fail = 0;
      extras_done = 0;
      cyc = 0;
      m_blk = 0;
      m_pdv = 1'b0;
      model_hash = IV;
      m_if.start = 1'b0;
      m_if.first = 1'b0;
      m_if.abort = 1'b0;
      m_if.block_in = '0;
      reset_n = 1'b0;
      rx_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 256'(m_if.ready), 256'(1));
      chk("reset_digest_valid", 256'(m_if.digest_valid), 256'(0));
      chk("reset_digest", m_if.digest, IV);
      reset_n = 1'b1;
      rx_n = 1'b1;

      // Known answers
      submit(ABC_BLK, 1'b1, 1'b1, 1'b0);
      drain();
      chk("abc_kat", m_if.digest, ABC_KAT);
      submit(EMPTY_BLK, 1'b1, 1'b1, 1'b0);
      drain();
      chk("empty_kat", m_if.digest, EMPTY_KAT);
      submit(TWO_B1, 1'b1, 1'b1, 1'b0);
      submit(TWO_B2, 1'b0, 1'b1, 1'b0);
      drain();
      chk("two_block_kat", m_if.digest, TWO_KAT);

      // start hammered every cycle while busy
      submit(ABC_BLK, 1'b1, 1'b1, 1'b0);
      busy = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_if.ready === 1'b1) break;
         m_if.start = 1'b1;
         m_if.first = 1'($urandom_range(0, 1));
         m_if.block_in = rand_block();
         busy++;
      end
      m_if.start = 1'b0;
      chk("busy_window_cycles", 256'(busy), 256'(65));
      drain();
      chk("abc_under_start_spam", m_if.digest, ABC_KAT);

      // abort 20 cycles into block 2, then resubmit
      submit(TWO_B1, 1'b1, 1'b1, 1'b0);
      drain();
      inter = model_hash;
      submit(TWO_B2, 1'b0, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      m_if.abort = 1'b1;
      @(posedge clk);
      #1;
      m_if.abort = 1'b0;
      chk("abort_ready", 256'(m_if.ready), 256'(1));
      chk("abort_digest_valid", 256'(m_if.digest_valid), 256'(0));
      chk("abort_digest_kept", m_if.digest, inter);
      @(negedge clk);
      m_if.abort = 1'b1;
      @(posedge clk);
      #1;
      m_if.abort = 1'b0;
      chk("idle_abort_ready", 256'(m_if.ready), 256'(1));
      chk("idle_abort_digest", m_if.digest, inter);
      submit(TWO_B2, 1'b0, 1'b1, 1'b0);
      drain();
      chk("two_block_resubmit", m_if.digest, TWO_KAT);

      // asynchronous reset between edges, mid-ROUND
      submit(rand_block(), 1'b1, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset_ready", 256'(m_if.ready), 256'(1));
      chk("async_reset_digest_valid", 256'(m_if.digest_valid), 256'(0));
      chk("async_reset_digest", m_if.digest, IV);
      exp_q.delete();
      model_hash = IV;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      submit(ABC_BLK, 1'b0, 1'b1, 1'b0);
      drain();
      chk("abc_after_reset_first0", m_if.digest, ABC_KAT);

      // random chained blocks, sometimes with abort alongside start
      for (int i = 0; i < 10; i++) begin
         submit(rand_block(), 1'($urandom_range(0, 2) == 0), 1'b1, 1'($urandom_range(0, 3) == 0));
      end
      drain();

      n = 0;
      while (extras_done < 3 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (extras_done < 3) note_fail("extras_timeout");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
